// File: rtl/rv32i_fetch_decode_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_decode_pkg
// Shared constants for the RV32I decode stage: base opcode values, the
// ALUSel / WBSel / access_size codes driven to the datapath, the immediate
// format selector used between the control decoder and the immediate
// generator, and small helpers for the funct3-driven decodes.
// ---------------------------------------------------------------------------
package rv32i_fetch_decode_pkg;

   // Base RV32I opcodes (instruction[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_CCC    = 7'b1110011;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_LUIOP = 4'd10;
   localparam logic [3:0] ALU_JADD  = 4'd11;

   // Write-back source select
   localparam logic [1:0] WB_MEM     = 2'd0;
   localparam logic [1:0] WB_ALU     = 2'd1;
   localparam logic [1:0] WB_PC_NEXT = 2'd2;

   // Data memory access size
   localparam logic [1:0] SIZE_BYTE     = 2'd0;
   localparam logic [1:0] SIZE_HALFWORD = 2'd1;
   localparam logic [1:0] SIZE_WORD     = 2'd2;

   // Immediate layout selected by the control decoder
   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   // Opcodes without an immediate (OP, FENCE, SYSTEM, unknown) yield IMM_NONE,
   // which the generator turns into zero.
   function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC:             imm_fmt_of = IMM_U;
         OPC_JAL:                        imm_fmt_of = IMM_J;
         OPC_JALR, OPC_LOAD, OPC_OPIMM:  imm_fmt_of = IMM_I;
         OPC_BRANCH:                     imm_fmt_of = IMM_B;
         OPC_STORE:                      imm_fmt_of = IMM_S;
         default:                        imm_fmt_of = IMM_NONE;
      endcase
   endfunction

   // ins[30] only selects SUB for register-register ops; for OP-IMM that bit
   // belongs to the immediate, except on the shift-right encoding where it
   // selects SRA in both forms.
   function automatic logic [3:0] alu_op(input logic [2:0] funct3,
                                         input logic       alt,
                                         input logic       reg_reg);
      case (funct3)
         3'b000:  alu_op = (reg_reg && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// ---------------------------------------------------------------------------
// rv32i_imm_gen
// Assembles and sign-extends the immediate of an RV32I instruction for the
// layout chosen by the control decoder. Purely combinational.
//   instruction  in  32  instruction word
//   fmt          in   3  immediate layout (IMM_NONE gives zero)
//   imm          out 32  sign-extended immediate
// ---------------------------------------------------------------------------
module rv32i_imm_gen
   import rv32i_fetch_decode_pkg::*;
(
   input  logic [31:0] instruction,
   input  imm_fmt_t    fmt,
   output logic [31:0] imm
);

   always_comb begin
      case (fmt)
         IMM_I:   imm = {{20{instruction[31]}}, instruction[31:20]};
         IMM_S:   imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         IMM_B:   imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
         IMM_U:   imm = {instruction[31:12], 12'b0};
         IMM_J:   imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_fetch_decode.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_decode
// Decode stage of the single-cycle RV32I core. Splits the instruction into
// register addresses and immediate and drives every datapath control. The
// only state is a valid flag; until it is set after reset, all controls
// are held at a harmless NOP.
//   clk, rst              clock (rising edge), async active-high reset
//   instruction, PC       current instruction word and its address
//   BrEq, BrLt            branch compare flags from execute
//   opcode                instruction[6:0]
//   addr_rs1/rs2/rd       register addresses
//   imm                   sign-extended immediate
//   PCSel ASel BSel       PC mux, ALU operand A/B muxes
//   ALUSel BrUn           ALU operation, unsigned branch compare
//   MemRW RdUn access_size data memory write, zero-extend load, size
//   RegWE WBSel           register write enable, write-back source
// ---------------------------------------------------------------------------
module rv32i_fetch_decode
   import rv32i_fetch_decode_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00FF_FFFC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic [31:0] PC,
   input  logic        BrEq,
   input  logic        BrLt,
   output logic [6:0]  opcode,
   output logic [4:0]  addr_rs1,
   output logic [4:0]  addr_rs2,
   output logic [4:0]  addr_rd,
   output logic [31:0] imm,
   output logic        PCSel,
   output logic        ASel,
   output logic        BSel,
   output logic [3:0]  ALUSel,
   output logic        BrUn,
   output logic        MemRW,
   output logic        RdUn,
   output logic [1:0]  access_size,
   output logic        RegWE,
   output logic [1:0]  WBSel
);

   logic       valid;
   logic [2:0] funct3;
   logic       alt;
   logic       branch_taken;
   logic       reg_we_raw;
   imm_fmt_t   fmt;

   assign opcode   = instruction[6:0];
   assign addr_rd  = instruction[11:7];
   assign funct3   = instruction[14:12];
   assign addr_rs1 = instruction[19:15];
   assign addr_rs2 = instruction[24:20];
   assign alt      = instruction[30];

   // Valid drops the moment reset is applied and comes back on the first
   // clock edge after release, so the first fetched word is never acted on
   // before instruction memory has produced it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid <= 1'b0;
      else     valid <= 1'b1;
   end

   // An invalid stage selects no immediate, which forces imm to zero.
   always_comb begin
      fmt = valid ? imm_fmt_of(opcode) : IMM_NONE;
   end

   rv32i_imm_gen u_imm_gen (
      .instruction (instruction),
      .fmt         (fmt),
      .imm         (imm)
   );

   // BLT/BLTU share the BrLt sense, BGE/BGEU its complement; execute has
   // already applied signedness from BrUn. Reserved funct3 never branches.
   always_comb begin
      case (funct3)
         3'b000:         branch_taken = BrEq;
         3'b001:         branch_taken = !BrEq;
         3'b100, 3'b110: branch_taken = BrLt;
         3'b101, 3'b111: branch_taken = !BrLt;
         default:        branch_taken = 1'b0;
      endcase
   end

   // Start from the NOP control set and override only what each opcode
   // needs; FENCE, SYSTEM and unknown opcodes keep the NOP set.
   always_comb begin
      PCSel       = 1'b1;
      ASel        = 1'b1;
      BSel        = 1'b0;
      ALUSel      = ALU_ADD;
      BrUn        = 1'b0;
      MemRW       = 1'b0;
      RdUn        = 1'b0;
      access_size = SIZE_WORD;
      reg_we_raw  = 1'b0;
      WBSel       = WB_ALU;
      if (valid) begin
         case (opcode)
            OPC_LUI: begin
               ALUSel     = ALU_LUIOP;
               reg_we_raw = 1'b1;
            end
            OPC_AUIPC: begin
               ASel       = 1'b0;
               reg_we_raw = 1'b1;
            end
            OPC_JAL: begin
               ASel       = 1'b0;
               PCSel      = 1'b0;
               WBSel      = WB_PC_NEXT;
               reg_we_raw = 1'b1;
            end
            OPC_JALR: begin
               ALUSel     = ALU_JADD;
               PCSel      = 1'b0;
               WBSel      = WB_PC_NEXT;
               reg_we_raw = 1'b1;
            end
            OPC_BRANCH: begin
               ASel  = 1'b0;
               BrUn  = funct3[2] & funct3[1];
               PCSel = !branch_taken;
            end
            OPC_LOAD: begin
               WBSel       = WB_MEM;
               reg_we_raw  = 1'b1;
               access_size = funct3[1:0];
               RdUn        = funct3[2];
            end
            OPC_STORE: begin
               MemRW       = 1'b1;
               access_size = funct3[1:0];
            end
            OPC_OPIMM: begin
               ALUSel     = alu_op(funct3, alt, 1'b0);
               reg_we_raw = 1'b1;
            end
            OPC_OP: begin
               BSel       = 1'b1;
               ALUSel     = alu_op(funct3, alt, 1'b1);
               reg_we_raw = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // x0 is hard-wired to zero, so writes to it are suppressed here.
   assign RegWE = reg_we_raw && (addr_rd != 5'd0);

   // While decode is invalid the fetch stage must be parked on the reset vector.
   pc_parked_while_invalid: assert property (
      @(posedge clk) disable iff (rst) !valid |-> (PC == RESET_PC)
   );

endmodule

// File: tb/tb_rv32i_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_rv32i_fetch_decode
// Scoreboard bench for the decode stage. The driver applies one instruction
// per cycle shortly after the rising edge and pushes the reference model's
// expectation; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_rv32i_fetch_decode;

   localparam logic [31:0] RESET_PC = 32'h00FF_FFFC;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        br_eq;
   logic        br_lt;
   logic [6:0]  opcode;
   logic [4:0]  addr_rs1;
   logic [4:0]  addr_rs2;
   logic [4:0]  addr_rd;
   logic [31:0] imm;
   logic        pc_sel;
   logic        a_sel;
   logic        b_sel;
   logic [3:0]  alu_sel;
   logic        br_un;
   logic        mem_rw;
   logic        rd_un;
   logic [1:0]  access_size;
   logic        reg_we;
   logic [1:0]  wb_sel;

   typedef struct packed {
      logic [31:0] ins;
      logic [6:0]  opcode;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        imm_care;
      logic        pc_sel;
      logic        a_sel;
      logic        b_sel;
      logic [3:0]  alu_sel;
      logic        br_un;
      logic        mem_rw;
      logic        rd_un;
      logic [1:0]  access_size;
      logic        reg_we;
      logic [1:0]  wb_sel;
   } expect_t;

   expect_t     exp_q[$];
   expect_t     mon_e;
   int          checks = 0;
   int          errors = 0;
   logic        model_valid = 1'b0;

   rv32i_fetch_decode #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .PC          (pc),
      .BrEq        (br_eq),
      .BrLt        (br_lt),
      .opcode      (opcode),
      .addr_rs1    (addr_rs1),
      .addr_rs2    (addr_rs2),
      .addr_rd     (addr_rd),
      .imm         (imm),
      .PCSel       (pc_sel),
      .ASel        (a_sel),
      .BSel        (b_sel),
      .ALUSel      (alu_sel),
      .BrUn        (br_un),
      .MemRW       (mem_rw),
      .RdUn        (rd_un),
      .access_size (access_size),
      .RegWE       (reg_we),
      .WBSel       (wb_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: RV32I semantics expressed directly. Immediates come
   // from arithmetic shifts of the word, branch outcomes from comparing the
   // actual operand values.
   function automatic expect_t modelExpect(input logic [31:0] ins,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        valid);
      expect_t           e;
      logic signed [31:0] s;
      logic [2:0]        f3;
      logic [3:0]        alu_by_f3 [8];
      logic              taken;
      alu_by_f3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      s  = ins;
      f3 = ins[14:12];
      e  = '0;
      e.ins         = ins;
      e.opcode      = ins[6:0];
      e.rs1         = ins[19:15];
      e.rs2         = ins[24:20];
      e.rd          = ins[11:7];
      e.imm_care    = 1'b1;
      e.pc_sel      = 1'b1;
      e.a_sel       = 1'b1;
      e.alu_sel     = 4'd0;
      e.access_size = 2'd2;
      e.wb_sel      = 2'd1;
      if (!valid) return e;
      case (ins[6:0])
         7'h37: begin
            e.imm = ins & 32'hFFFF_F000;
            e.alu_sel = 4'd10;
            e.reg_we = 1'b1;
         end
         7'h17: begin
            e.imm = ins & 32'hFFFF_F000;
            e.a_sel = 1'b0;
            e.reg_we = 1'b1;
         end
         7'h6F: begin
            e.imm = (32'(s >>> 31) << 20) | (32'(ins[19:12]) << 12) |
                    (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            e.a_sel = 1'b0;
            e.pc_sel = 1'b0;
            e.wb_sel = 2'd2;
            e.reg_we = 1'b1;
         end
         7'h67: begin
            e.imm = 32'(s >>> 20);
            e.alu_sel = 4'd11;
            e.pc_sel = 1'b0;
            e.wb_sel = 2'd2;
            e.reg_we = 1'b1;
         end
         7'h63: begin
            e.imm = (32'(s >>> 31) << 12) | (32'(ins[7]) << 11) |
                    (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            e.a_sel = 1'b0;
            e.br_un = (f3 == 3'd6) || (f3 == 3'd7);
            case (f3)
               3'd0:    taken = (a == b);
               3'd1:    taken = (a != b);
               3'd4:    taken = ($signed(a) <  $signed(b));
               3'd5:    taken = ($signed(a) >= $signed(b));
               3'd6:    taken = (a <  b);
               3'd7:    taken = (a >= b);
               default: taken = 1'b0;
            endcase
            e.pc_sel = !taken;
         end
         7'h03: begin
            e.imm = 32'(s >>> 20);
            e.wb_sel = 2'd0;
            e.reg_we = 1'b1;
            e.access_size = f3[1:0];
            e.rd_un = f3[2];
         end
         7'h23: begin
            e.imm = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
            e.mem_rw = 1'b1;
            e.access_size = f3[1:0];
         end
         7'h13: begin
            e.imm = 32'(s >>> 20);
            e.reg_we = 1'b1;
            e.alu_sel = (f3 == 3'd5 && ins[30]) ? 4'd7 : alu_by_f3[f3];
         end
         7'h33: begin
            e.imm_care = 1'b0;
            e.b_sel = 1'b1;
            e.reg_we = 1'b1;
            e.alu_sel = alu_by_f3[f3];
            if (ins[30] && f3 == 3'd0) e.alu_sel = 4'd1;
            if (ins[30] && f3 == 3'd5) e.alu_sel = 4'd7;
         end
         default: e.imm_care = 1'b0;
      endcase
      if (ins[11:7] == 5'd0) e.reg_we = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] randomInstruction();
      logic [6:0]  opcodes [12];
      logic [2:0]  load_f3 [5];
      logic [31:0] ins;
      opcodes = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
      load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      ins = $urandom;
      ins[6:0] = opcodes[$urandom_range(0, 11)];
      if (ins[6:0] == 7'h03) ins[14:12] = load_f3[$urandom_range(0, 4)];
      if (ins[6:0] == 7'h23) ins[14:12] = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      return ins;
   endfunction

   // Waits for the next rising edge, then drives one cycle of stimulus and
   // queues what the monitor should see on the following falling edge.
   task automatic applyStimulus(input logic [31:0] ins, input logic rst_val,
                                input logic [31:0] a, input logic [31:0] b);
      logic uns;
      @(posedge clk);
      #2;
      if (rst == 1'b0) model_valid = 1'b1;
      if (rst_val) model_valid = 1'b0;
      uns = (ins[6:0] == 7'h63) && (ins[14:13] == 2'b11);
      rst         = rst_val;
      instruction = ins;
      br_eq       = (a == b);
      br_lt       = uns ? (a < b) : ($signed(a) < $signed(b));
      pc          = model_valid ? $urandom : RESET_PC;
      exp_q.push_back(modelExpect(ins, a, b, model_valid));
   endtask

   task automatic checkOutput(input string name, input logic [31:0] ins,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s ins=%h actual=%h expected=%h", name, ins, act, exp);
      end
   endtask

   // Monitor: compares every queued expectation against the live outputs.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("opcode",      mon_e.ins, 32'(opcode),      32'(mon_e.opcode));
            checkOutput("addr_rs1",    mon_e.ins, 32'(addr_rs1),    32'(mon_e.rs1));
            checkOutput("addr_rs2",    mon_e.ins, 32'(addr_rs2),    32'(mon_e.rs2));
            checkOutput("addr_rd",     mon_e.ins, 32'(addr_rd),     32'(mon_e.rd));
            if (mon_e.imm_care)
               checkOutput("imm",      mon_e.ins, imm,              mon_e.imm);
            checkOutput("PCSel",       mon_e.ins, 32'(pc_sel),      32'(mon_e.pc_sel));
            checkOutput("ASel",        mon_e.ins, 32'(a_sel),       32'(mon_e.a_sel));
            checkOutput("BSel",        mon_e.ins, 32'(b_sel),       32'(mon_e.b_sel));
            checkOutput("ALUSel",      mon_e.ins, 32'(alu_sel),     32'(mon_e.alu_sel));
            checkOutput("BrUn",        mon_e.ins, 32'(br_un),       32'(mon_e.br_un));
            checkOutput("MemRW",       mon_e.ins, 32'(mem_rw),      32'(mon_e.mem_rw));
            checkOutput("RdUn",        mon_e.ins, 32'(rd_un),       32'(mon_e.rd_un));
            checkOutput("access_size", mon_e.ins, 32'(access_size), 32'(mon_e.access_size));
            checkOutput("RegWE",       mon_e.ins, 32'(reg_we),      32'(mon_e.reg_we));
            checkOutput("WBSel",       mon_e.ins, 32'(wb_sel),      32'(mon_e.wb_sel));
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      rst         = 1'b1;
      instruction = 32'h0050_0093;
      pc          = RESET_PC;
      br_eq       = 1'b0;
      br_lt       = 1'b0;

      // Reset, release (still NOP before the first edge), then addi x1,x0,5
      applyStimulus(32'h0050_0093, 1'b1, 32'd0, 32'd0);
      applyStimulus(32'h0050_0093, 1'b0, 32'd0, 32'd0);
      applyStimulus(32'h0050_0093, 1'b0, 32'd0, 32'd0);
      // beq x0,x0,-8 taken and not taken
      applyStimulus(32'hFE00_0CE3, 1'b0, 32'd7, 32'd7);
      applyStimulus(32'hFE00_0CE3, 1'b0, 32'd7, 32'd9);
      // lbu, sw, jalr x0, lui, ecall
      applyStimulus(32'h0031_4283, 1'b0, 32'd0, 32'd0);
      applyStimulus(32'hFE61_2E23, 1'b0, 32'd0, 32'd0);
      applyStimulus(32'h0000_8067, 1'b0, 32'd0, 32'd0);
      applyStimulus(32'h1234_51B7, 1'b0, 32'd0, 32'd0);
      applyStimulus(32'h0000_0073, 1'b0, 32'd0, 32'd0);
      // Reset mid-run: NOP immediately, and again until the next edge
      applyStimulus(32'h1234_51B7, 1'b1, 32'd0, 32'd0);
      applyStimulus(32'h1234_51B7, 1'b0, 32'd0, 32'd0);
      applyStimulus(32'h1234_51B7, 1'b0, 32'd0, 32'd0);

      for (int i = 0; i < 800; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
         applyStimulus(randomInstruction(), ($urandom_range(0, 49) == 0), a, b);
      end

      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'd0, 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
